head_table: RTL and testbench
=============================

Name: head_table

Overview:
- Responder end of the head-table interface that the data table drives as master.
- Stores one head pointer and its valid bit per hash bucket in a single-clock dual-port RAM.
- Serves pipelined head-pointer lookups, and applies head-pointer updates issued on insert/delete.
- Provides the same run/done RAM-clear handshake as the data table, so both tables can be zeroed together.

Parameters:
BUCKET_WIDTH, 8, hash bucket index width; table depth is 2**BUCKET_WIDTH.
HEAD_PTR_WIDTH, 10, width of the data-table address stored as head pointer.

Ports:
clk_i  input  1  clock; all logic on rising edge.
rst_i  input  1  asynchronous, active-high reset.
rd_bucket_i  input  BUCKET_WIDTH  lookup bucket index.
rd_en_i  input  1  lookup request.
rd_ready_o  output  1  lookup accepted when rd_en_i && rd_ready_o.
rd_head_ptr_o  output  HEAD_PTR_WIDTH  returned head pointer.
rd_head_ptr_val_o  output  1  returned head pointer valid (bucket non-empty).
rd_valid_o  output  1  one-cycle strobe qualifying rd_head_ptr_o / rd_head_ptr_val_o.
wr_bucket_i  input  BUCKET_WIDTH  update bucket index.
wr_head_ptr_i  input  HEAD_PTR_WIDTH  new head pointer.
wr_head_ptr_val_i  input  1  new valid bit; 0 marks bucket empty.
wr_en_i  input  1  update request.
wr_ready_o  output  1  update accepted when wr_en_i && wr_ready_o.
clear_ram_run_i  input  1  start clearing all buckets.
clear_ram_done_o  output  1  one-cycle pulse on final clear write.

Behaviour:
- Clock/reset: one clock clk_i; rst_i is asynchronous and active-high.
- Reset values:
  - State IDLE; rd_ready_o=1, wr_ready_o=1.
  - rd_valid_o=0, rd_head_ptr_o=0, rd_head_ptr_val_o=0, clear_ram_done_o=0.
  - Clear counter = 0.
  - RAM contents are not reset; software/top level must run a clear before first use.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_ram_run_i; counter loads 0.
  - CLEAR: each cycle writes {ptr=0, val=0} to the counter address, then increments the counter.
  - When counter == all-ones: that write occurs, clear_ram_done_o=1 for that cycle, next state IDLE.
  - clear_ram_run_i asserted during CLEAR restarts the counter at 0 and suppresses the pending done.
  - Clear takes exactly 2**BUCKET_WIDTH cycles.
- Ready during CLEAR: rd_ready_o=0 and wr_ready_o=0; rd_en_i and wr_en_i are ignored (no RAM access, no side effects).
- Lookup latency is fixed at 2:
  - Lookup accepted in cycle t presents the address to the RAM in t.
  - RAM output is registered in t+1.
  - rd_valid_o=1 with data in t+2.
  - Back-to-back acceptance every cycle; no read backpressure.
  - Lookups in flight when CLEAR starts still complete with rd_valid_o; data is whatever the RAM returned.
- Update: an accepted write commits at the end of the accept cycle; a lookup accepted in t+1 or later sees it.
- Same bucket read and write in the same cycle (port A read, port B write): RAM is old-data read-during-write, so the lookup returns the pre-write value unless bypass is enabled.
- Width rules: stored word is {val, ptr} = HEAD_PTR_WIDTH+1 bits. The clear counter is BUCKET_WIDTH bits and wraps to 0 only via the restart path.
- Reset mid-clear: returns to IDLE immediately; no done pulse; partially cleared RAM is left as is.

Optional Feature:
- Macro: HEAD_TABLE_BYPASS_EN.
- Defined: two-stage forwarding. For a lookup accepted at t, any accepted update to the same bucket in t or t+1 replaces the returned {ptr,val}; the later update wins. Lookups return the architecturally latest value.
- Undefined: no forwarding; a write at t or t+1 to the same bucket is not reflected in the lookup accepted at t.
- Latency is 2 in both cases.

Test Plan:
- Clear, then lookup: reset, pulse clear_ram_run_i with BUCKET_WIDTH=8 -> ready low for 256 cycles; done pulses on cycle 256; lookups of buckets 0, 17 and 255 return ptr=0, val=0, each 2 cycles after accept.
- Update then lookup: write bucket 5 <- ptr 0x2A, val 1; next-cycle lookup of 5 -> ptr 0x2A, val 1 at t+2. Write bucket 5 <- val 0 -> lookup returns val 0.
- Back-to-back reads: lookups of buckets 1, 2, 3 on consecutive cycles, preloaded 0x11/0x22/0x33 -> three consecutive rd_valid_o with 0x11, 0x22, 0x33 in order.
- Collision: lookup bucket 9 (old ptr 0x04) at t, write 9 <- 0x3F at t+1 -> returns 0x3F with HEAD_TABLE_BYPASS_EN, 0x04 without.
- Clear blocking: assert wr_en_i to bucket 3 during CLEAR -> ignored; after done, bucket 3 reads val 0. Re-pulse run mid-clear -> done arrives 256 cycles after the re-pulse.
- Async reset mid-clear at cycle 100 -> outputs go to reset values immediately; no done pulse; ready=1.

Source files
------------

// File: rtl/head_table.sv
// Head-pointer table: one {valid, head_ptr} word per hash bucket, with pipelined lookups,
// updates and a run/done RAM clear. Define HEAD_TABLE_BYPASS_EN to forward in-flight updates into lookups.
module head_table #(
   parameter int BUCKET_WIDTH   = 8,
   parameter int HEAD_PTR_WIDTH = 10
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [BUCKET_WIDTH-1:0]   rd_bucket_i,
   input  logic                      rd_en_i,
   output logic                      rd_ready_o,
   output logic [HEAD_PTR_WIDTH-1:0] rd_head_ptr_o,
   output logic                      rd_head_ptr_val_o,
   output logic                      rd_valid_o,
   input  logic [BUCKET_WIDTH-1:0]   wr_bucket_i,
   input  logic [HEAD_PTR_WIDTH-1:0] wr_head_ptr_i,
   input  logic                      wr_head_ptr_val_i,
   input  logic                      wr_en_i,
   output logic                      wr_ready_o,
   input  logic                      clear_ram_run_i,
   output logic                      clear_ram_done_o
);

   localparam int DEPTH  = 2 ** BUCKET_WIDTH;
   localparam int WORD_W = HEAD_PTR_WIDTH + 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [BUCKET_WIDTH-1:0] cnt_q, cnt_d;
   logic                    done_s;

   logic                    rd_fire_s;
   logic                    wr_fire_s;
   logic [WORD_W-1:0]       wr_word_s;
   logic                    ram_we_s;
   logic [BUCKET_WIDTH-1:0] ram_waddr_s;
   logic [WORD_W-1:0]       ram_wdata_s;

   logic [WORD_W-1:0]       mem [DEPTH];
   logic [WORD_W-1:0]       ram_rdata_q;

   logic                    s1_valid_q;
   logic [WORD_W-1:0]       out_word_s;
   logic [WORD_W-1:0]       out_word_q, out_word_d;
   logic                    out_valid_q;

`ifdef HEAD_TABLE_BYPASS_EN
   logic [BUCKET_WIDTH-1:0] s1_bucket_q;
   logic                    s1_hit_q, s1_hit_d;
   logic [WORD_W-1:0]       s1_word_q;
`endif

   assign rd_ready_o        = (state_q == ST_IDLE);
   assign wr_ready_o        = (state_q == ST_IDLE);
   assign rd_fire_s         = rd_en_i && (state_q == ST_IDLE);
   assign wr_fire_s         = wr_en_i && (state_q == ST_IDLE);
   assign wr_word_s         = {wr_head_ptr_val_i, wr_head_ptr_i};
   assign clear_ram_done_o  = done_s;
   assign rd_valid_o        = out_valid_q;
   assign rd_head_ptr_o     = out_word_q[HEAD_PTR_WIDTH-1:0];
   assign rd_head_ptr_val_o = out_word_q[HEAD_PTR_WIDTH];

   // Clear FSM next-state: a run during CLEAR restarts the sweep and drops the pending done
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clear_ram_run_i) begin
               state_d = ST_CLEAR;
               cnt_d   = {BUCKET_WIDTH{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (clear_ram_run_i) begin
               cnt_d = {BUCKET_WIDTH{1'b0}};
            end else if (cnt_q == {BUCKET_WIDTH{1'b1}}) begin
               done_s  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + BUCKET_WIDTH'(1'b1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {BUCKET_WIDTH{1'b0}};
         end
      endcase
   end

   // FSM state and clear counter
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= {BUCKET_WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Write port: the clear sweep owns the port while clearing, otherwise accepted updates
   always_comb begin
      ram_we_s    = 1'b0;
      ram_waddr_s = wr_bucket_i;
      ram_wdata_s = wr_word_s;
      if (state_q == ST_CLEAR) begin
         ram_we_s    = 1'b1;
         ram_waddr_s = cnt_q;
         ram_wdata_s = {WORD_W{1'b0}};
      end else begin
         ram_we_s = wr_fire_s;
      end
   end

   // Dual-port RAM with registered read; read-during-write returns the old word
   always_ff @(posedge clk_i) begin
      if (ram_we_s) begin
         mem[ram_waddr_s] <= ram_wdata_s;
      end
      if (rd_fire_s) begin
         ram_rdata_q <= mem[rd_bucket_i];
      end
   end

`ifdef HEAD_TABLE_BYPASS_EN
   // Forwarding: an update in the accept cycle is captured in stage 1, one in the following cycle overrides at stage 2
   always_comb begin
      s1_hit_d = wr_fire_s && (wr_bucket_i == rd_bucket_i);
      if (wr_fire_s && (wr_bucket_i == s1_bucket_q)) begin
         out_word_s = wr_word_s;
      end else if (s1_hit_q) begin
         out_word_s = s1_word_q;
      end else begin
         out_word_s = ram_rdata_q;
      end
   end

   // Stage-1 forwarding registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_bucket_q <= {BUCKET_WIDTH{1'b0}};
         s1_hit_q    <= 1'b0;
         s1_word_q   <= {WORD_W{1'b0}};
      end else if (rd_fire_s) begin
         s1_bucket_q <= rd_bucket_i;
         s1_hit_q    <= s1_hit_d;
         s1_word_q   <= wr_word_s;
      end else begin
         s1_hit_q    <= 1'b0;
      end
   end
`else
   assign out_word_s = ram_rdata_q;
`endif

   // Output word holds its last value between lookups
   always_comb begin
      if (s1_valid_q) begin
         out_word_d = out_word_s;
      end else begin
         out_word_d = out_word_q;
      end
   end

   // Lookup pipeline valid and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_word_q  <= {WORD_W{1'b0}};
      end else begin
         s1_valid_q  <= rd_fire_s;
         out_valid_q <= s1_valid_q;
         out_word_q  <= out_word_d;
      end
   end

endmodule

// File: tb/tb_head_table.sv
// Directed self-checking bench for head_table (default parameters).
`timescale 1ns/1ps
module tb_head_table;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [7:0] rd_bucket_i;
   logic       rd_en_i;
   logic       rd_ready_o;
   logic [9:0] rd_head_ptr_o;
   logic       rd_head_ptr_val_o;
   logic       rd_valid_o;
   logic [7:0] wr_bucket_i;
   logic [9:0] wr_head_ptr_i;
   logic       wr_head_ptr_val_i;
   logic       wr_en_i;
   logic       wr_ready_o;
   logic       clear_ram_run_i;
   logic       clear_ram_done_o;

   int n_cmp = 0;
   int n_err = 0;

`ifdef HEAD_TABLE_BYPASS_EN
   localparam logic [9:0] EXP_COLL_NEXT = 10'h03F;
   localparam logic [9:0] EXP_COLL_SAME = 10'h015;
`else
   localparam logic [9:0] EXP_COLL_NEXT = 10'h004;
   localparam logic [9:0] EXP_COLL_SAME = 10'h03F;
`endif

   head_table #(.BUCKET_WIDTH(8), .HEAD_PTR_WIDTH(10)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .rd_bucket_i(rd_bucket_i), .rd_en_i(rd_en_i), .rd_ready_o(rd_ready_o),
      .rd_head_ptr_o(rd_head_ptr_o), .rd_head_ptr_val_o(rd_head_ptr_val_o), .rd_valid_o(rd_valid_o),
      .wr_bucket_i(wr_bucket_i), .wr_head_ptr_i(wr_head_ptr_i), .wr_head_ptr_val_i(wr_head_ptr_val_i),
      .wr_en_i(wr_en_i), .wr_ready_o(wr_ready_o),
      .clear_ram_run_i(clear_ram_run_i), .clear_ram_done_o(clear_ram_done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic cycle();
      @(posedge clk_i);
      #2;
   endtask

   // Leaves the caller in the cycle after acceptance
   task automatic start_lookup(input logic [7:0] b);
      rd_bucket_i = b;
      rd_en_i     = 1'b1;
      cycle();
      rd_en_i     = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] b, input logic [9:0] p, input logic v);
      wr_bucket_i       = b;
      wr_head_ptr_i     = p;
      wr_head_ptr_val_i = v;
      wr_en_i           = 1'b1;
      cycle();
      wr_en_i           = 1'b0;
   endtask

   task automatic test_reset();
      cycle();
      n_cmp++; if (rd_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_rd_ready got %b want 1", rd_ready_o); end
      n_cmp++; if (wr_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got %b want 1", wr_ready_o); end
      n_cmp++; if (rd_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", rd_valid_o); end
      n_cmp++; if (rd_head_ptr_o !== 10'h000) begin n_err++; $display("FAIL reset_ptr got %h want 000", rd_head_ptr_o); end
      n_cmp++; if (rd_head_ptr_val_o !== 1'b0) begin n_err++; $display("FAIL reset_val got %b want 0", rd_head_ptr_val_o); end
      n_cmp++; if (clear_ram_done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", clear_ram_done_o); end
      rst_i = 1'b0;
      cycle();
   endtask

   task automatic test_clear();
      logic [7:0] lb [3];
      int low, dcyc, dcnt;
      lb = '{8'd0, 8'd17, 8'd255};
      low = 0; dcyc = 0; dcnt = 0;
      clear_ram_run_i = 1'b1;
      cycle();
      clear_ram_run_i = 1'b0;
      for (int i = 1; i < 400; i++) begin
         if (rd_ready_o) break;
         low++;
         if (clear_ram_done_o) begin dcnt++; dcyc = i; end
         cycle();
      end
      n_cmp++; if (low !== 256) begin n_err++; $display("FAIL clear_ready_low got %0d want 256", low); end
      n_cmp++; if (dcyc !== 256) begin n_err++; $display("FAIL clear_done_cycle got %0d want 256", dcyc); end
      n_cmp++; if (dcnt !== 1) begin n_err++; $display("FAIL clear_done_count got %0d want 1", dcnt); end
      for (int k = 0; k < 3; k++) begin
         start_lookup(lb[k]);
         n_cmp++; if (rd_valid_o !== 1'b0) begin n_err++; $display("FAIL clear_lookup_early b=%0d got %b want 0", lb[k], rd_valid_o); end
         cycle();
         n_cmp++; if (rd_valid_o !== 1'b1) begin n_err++; $display("FAIL clear_lookup_valid b=%0d got %b want 1", lb[k], rd_valid_o); end
         n_cmp++; if ({rd_head_ptr_val_o, rd_head_ptr_o} !== 11'h000) begin n_err++; $display("FAIL clear_lookup_data b=%0d got %b/%h want 0/000", lb[k], rd_head_ptr_val_o, rd_head_ptr_o); end
      end
   endtask

   task automatic test_update();
      do_write(8'd5, 10'h02A, 1'b1);
      start_lookup(8'd5);
      cycle();
      n_cmp++; if (rd_valid_o !== 1'b1) begin n_err++; $display("FAIL update_valid got %b want 1", rd_valid_o); end
      n_cmp++; if ({rd_head_ptr_val_o, rd_head_ptr_o} !== {1'b1, 10'h02A}) begin n_err++; $display("FAIL update_data got %b/%h want 1/02a", rd_head_ptr_val_o, rd_head_ptr_o); end
      do_write(8'd5, 10'h02A, 1'b0);
      start_lookup(8'd5);
      cycle();
      n_cmp++; if ({rd_valid_o, rd_head_ptr_val_o} !== 2'b10) begin n_err++; $display("FAIL update_empty got valid=%b val=%b want valid=1 val=0", rd_valid_o, rd_head_ptr_val_o); end
   endtask

   task automatic test_back_to_back();
      do_write(8'd1, 10'h011, 1'b1);
      do_write(8'd2, 10'h022, 1'b1);
      do_write(8'd3, 10'h033, 1'b1);
      rd_en_i = 1'b1; rd_bucket_i = 8'd1;
      cycle();
      rd_bucket_i = 8'd2;
      cycle();
      rd_bucket_i = 8'd3;
      n_cmp++; if ({rd_valid_o, rd_head_ptr_o} !== {1'b1, 10'h011}) begin n_err++; $display("FAIL b2b_first got %b/%h want 1/011", rd_valid_o, rd_head_ptr_o); end
      cycle();
      rd_en_i = 1'b0;
      n_cmp++; if ({rd_valid_o, rd_head_ptr_o} !== {1'b1, 10'h022}) begin n_err++; $display("FAIL b2b_second got %b/%h want 1/022", rd_valid_o, rd_head_ptr_o); end
      cycle();
      n_cmp++; if ({rd_valid_o, rd_head_ptr_o} !== {1'b1, 10'h033}) begin n_err++; $display("FAIL b2b_third got %b/%h want 1/033", rd_valid_o, rd_head_ptr_o); end
      cycle();
      n_cmp++; if (rd_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b want 0", rd_valid_o); end
   endtask

   task automatic test_collision();
      do_write(8'd9, 10'h004, 1'b1);
      start_lookup(8'd9);
      wr_bucket_i = 8'd9; wr_head_ptr_i = 10'h03F; wr_head_ptr_val_i = 1'b1; wr_en_i = 1'b1;
      cycle();
      wr_en_i = 1'b0;
      n_cmp++; if ({rd_valid_o, rd_head_ptr_o} !== {1'b1, EXP_COLL_NEXT}) begin n_err++; $display("FAIL coll_next got %b/%h want 1/%h", rd_valid_o, rd_head_ptr_o, EXP_COLL_NEXT); end
      rd_en_i = 1'b1; rd_bucket_i = 8'd9;
      wr_en_i = 1'b1; wr_bucket_i = 8'd9; wr_head_ptr_i = 10'h015;
      cycle();
      rd_en_i = 1'b0; wr_en_i = 1'b0;
      cycle();
      n_cmp++; if ({rd_valid_o, rd_head_ptr_o} !== {1'b1, EXP_COLL_SAME}) begin n_err++; $display("FAIL coll_same got %b/%h want 1/%h", rd_valid_o, rd_head_ptr_o, EXP_COLL_SAME); end
      start_lookup(8'd9);
      cycle();
      n_cmp++; if ({rd_valid_o, rd_head_ptr_o} !== {1'b1, 10'h015}) begin n_err++; $display("FAIL coll_after got %b/%h want 1/015", rd_valid_o, rd_head_ptr_o); end
   endtask

   task automatic test_clear_block();
      int low, wlow, dcyc, dcnt, vseen;
      low = 0; wlow = 0; dcyc = 0; dcnt = 0; vseen = 0;
      clear_ram_run_i = 1'b1;
      cycle();
      clear_ram_run_i = 1'b0;
      for (int i = 1; i < 700; i++) begin
         if (rd_ready_o) break;
         low++;
         if (!wr_ready_o) wlow++;
         if (rd_valid_o) vseen++;
         if (clear_ram_done_o) begin dcnt++; dcyc = i; end
         wr_en_i         = (i == 10);
         wr_bucket_i     = 8'd3; wr_head_ptr_i = 10'h007; wr_head_ptr_val_i = 1'b1;
         rd_en_i         = (i == 20);
         rd_bucket_i     = 8'd3;
         clear_ram_run_i = (i == 100);
         cycle();
      end
      wr_en_i = 1'b0; rd_en_i = 1'b0; clear_ram_run_i = 1'b0;
      n_cmp++; if (low !== 356) begin n_err++; $display("FAIL restart_ready_low got %0d want 356", low); end
      n_cmp++; if (wlow !== 356) begin n_err++; $display("FAIL restart_wr_ready_low got %0d want 356", wlow); end
      n_cmp++; if (dcyc !== 356) begin n_err++; $display("FAIL restart_done_cycle got %0d want 356", dcyc); end
      n_cmp++; if (dcnt !== 1) begin n_err++; $display("FAIL restart_done_count got %0d want 1", dcnt); end
      n_cmp++; if (vseen !== 0) begin n_err++; $display("FAIL clear_read_ignored got %0d strobes want 0", vseen); end
      start_lookup(8'd3);
      cycle();
      n_cmp++; if ({rd_valid_o, rd_head_ptr_val_o, rd_head_ptr_o} !== {2'b10, 10'h000}) begin n_err++; $display("FAIL clear_write_ignored got %b/%b/%h want 1/0/000", rd_valid_o, rd_head_ptr_val_o, rd_head_ptr_o); end
   endtask

   task automatic test_reset_mid_clear();
      int dcnt, nrdy;
      dcnt = 0; nrdy = 0;
      do_write(8'd7, 10'h155, 1'b1);
      start_lookup(8'd7);
      cycle();
      n_cmp++; if ({rd_valid_o, rd_head_ptr_val_o, rd_head_ptr_o} !== {2'b11, 10'h155}) begin n_err++; $display("FAIL pre_reset_lookup got %b/%b/%h want 1/1/155", rd_valid_o, rd_head_ptr_val_o, rd_head_ptr_o); end
      clear_ram_run_i = 1'b1;
      cycle();
      clear_ram_run_i = 1'b0;
      repeat (99) cycle();
      n_cmp++; if (rd_ready_o !== 1'b0) begin n_err++; $display("FAIL mid_clear_ready got %b want 0", rd_ready_o); end
      #1 rst_i = 1'b1;
      #1;
      n_cmp++; if ({rd_ready_o, wr_ready_o} !== 2'b11) begin n_err++; $display("FAIL async_ready got %b%b want 11", rd_ready_o, wr_ready_o); end
      n_cmp++; if ({rd_valid_o, clear_ram_done_o} !== 2'b00) begin n_err++; $display("FAIL async_valid_done got %b%b want 00", rd_valid_o, clear_ram_done_o); end
      n_cmp++; if ({rd_head_ptr_val_o, rd_head_ptr_o} !== 11'h000) begin n_err++; $display("FAIL async_data got %b/%h want 0/000", rd_head_ptr_val_o, rd_head_ptr_o); end
      cycle();
      rst_i = 1'b0;
      for (int i = 0; i < 300; i++) begin
         cycle();
         if (clear_ram_done_o) dcnt++;
         if (!rd_ready_o || !wr_ready_o) nrdy++;
      end
      n_cmp++; if (dcnt !== 0) begin n_err++; $display("FAIL post_reset_done got %0d pulses want 0", dcnt); end
      n_cmp++; if (nrdy !== 0) begin n_err++; $display("FAIL post_reset_ready got %0d low cycles want 0", nrdy); end
   endtask

   initial begin
      rst_i = 1'b1;
      rd_bucket_i = 8'd0; rd_en_i = 1'b0;
      wr_bucket_i = 8'd0; wr_head_ptr_i = 10'h000; wr_head_ptr_val_i = 1'b0; wr_en_i = 1'b0;
      clear_ram_run_i = 1'b0;
      test_reset();
      test_clear();
      test_update();
      test_back_to_back();
      test_collision();
      test_clear_block();
      test_reset_mid_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
